// File: rtl/seg_display_driver.sv
// Six-digit common-anode 7-segment scan driver with double-buffered display data.
// New data is staged on load and promoted to the active copy only at a frame boundary.
module seg_display_driver #(
    parameter int unsigned DIGIT_TICKS = 1000,
    parameter int unsigned BLANK_TICKS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] lower0001,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower1000,
    input  logic [7:0] upper01,
    input  logic [7:0] upper10,
    input  logic       point,
    input  logic       col,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic [3:0] ind,
    output logic       col_out,
    output logic       frame_pulse
);

    localparam int unsigned TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_TICKS);
    localparam int unsigned DW = 54;

    // Packed data word: [47:0] digit bytes (digit 0 lowest), [51:48] {TIM,MAX,DAY,AVS},
    // [52] colon, [53] decimal point.
    logic [DW-1:0] in_data;
    logic [DW-1:0] stg_q;
    logic [DW-1:0] act_q;
    logic          pending_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    digit_q;
    logic          boundary;
    logic [7:0]    cur_byte;

    function automatic logic [6:0] decode(input logic [7:0] c);
        logic [6:0] s;
        case (c)
            8'h30:   s = 7'h3F;
            8'h31:   s = 7'h06;
            8'h32:   s = 7'h5B;
            8'h33:   s = 7'h4F;
            8'h34:   s = 7'h66;
            8'h35:   s = 7'h6D;
            8'h36:   s = 7'h7D;
            8'h37:   s = 7'h07;
            8'h38:   s = 7'h7F;
            8'h39:   s = 7'h6F;
            8'h2D:   s = 7'h40;
            8'h45:   s = 7'h79;
            8'h72:   s = 7'h50;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign in_data  = {point, col, TIM, MAX, DAY, AVS,
                       upper10, upper01, lower1000, lower0100, lower0010, lower0001};
    assign boundary = (tick_q == TICK_LAST) && (digit_q == 3'd5);

    always_comb begin
        cur_byte = 8'h00;
        case (digit_q)
            3'd0:    cur_byte = act_q[7:0];
            3'd1:    cur_byte = act_q[15:8];
            3'd2:    cur_byte = act_q[23:16];
            3'd3:    cur_byte = act_q[31:24];
            3'd4:    cur_byte = act_q[39:32];
            3'd5:    cur_byte = act_q[47:40];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q      <= '0;
            digit_q     <= '0;
            pending_q   <= 1'b0;
            stg_q       <= '0;
            act_q       <= '0;
            seg         <= '0;
            dp          <= 1'b0;
            an          <= '1;
            frame_pulse <= 1'b0;
        end else begin
            if (tick_q == TICK_LAST) begin
                tick_q  <= '0;
                digit_q <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
            end else begin
                tick_q <= tick_q + TW'(1);
            end

            frame_pulse <= boundary;

            // A load landing on the boundary bypasses staging straight into the active copy.
            if (load) begin
                stg_q <= in_data;
                if (boundary) begin
                    act_q     <= in_data;
                    pending_q <= 1'b0;
                end else begin
                    pending_q <= 1'b1;
                end
            end else if (boundary && pending_q) begin
                act_q     <= stg_q;
                pending_q <= 1'b0;
            end

            if (tick_q < BLANK_LIM) begin
                an  <= '1;
                seg <= '0;
                dp  <= 1'b0;
            end else begin
                an  <= ~(6'b000001 << digit_q);
                seg <= decode(cur_byte);
                dp  <= (digit_q == 3'd1) && act_q[53];
            end
        end
    end

    assign ind     = act_q[51:48];
    assign col_out = act_q[52];

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with an 8-tick slot and 2-tick blanking.
// Every cycle checks scan outputs against a counter model and hand-set expected codes.
module tb_seg_display_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lower0001 = '0, lower0010 = '0, lower0100 = '0, lower1000 = '0;
    logic [7:0] upper01 = '0, upper10 = '0;
    logic       point = 1'b0, col = 1'b0;
    logic       AVS = 1'b0, DAY = 1'b0, MAX = 1'b0, TIM = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic [3:0] ind;
    logic       col_out;
    logic       frame_pulse;

    int tests = 0;
    int fails = 0;
    int n = 0;
    logic [6:0] exp_code [6];
    logic       exp_point = 1'b0;

    seg_display_driver #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut (
        .clock(clock), .reset(reset), .load(load),
        .lower0001(lower0001), .lower0010(lower0010), .lower0100(lower0100),
        .lower1000(lower1000), .upper01(upper01), .upper10(upper10),
        .point(point), .col(col), .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
        .seg(seg), .dp(dp), .an(an), .ind(ind), .col_out(col_out),
        .frame_pulse(frame_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic set_exp(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                           input logic [6:0] c3, input logic [6:0] c4, input logic [6:0] c5,
                           input logic p);
        exp_code[0] = c0; exp_code[1] = c1; exp_code[2] = c2;
        exp_code[3] = c3; exp_code[4] = c4; exp_code[5] = c5;
        exp_point = p;
    endtask

    // Output at cycle n reflects counter value n-1 (tick = c%8, digit = (c/8)%6).
    task automatic step();
        int c, t, d;
        logic blank;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fp;
        @(posedge clock);
        #1;
        n++;
        c = n - 1;
        t = c % 8;
        d = (c / 8) % 6;
        blank = (t < 2);
        e_an  = blank ? 6'b111111 : ~(6'b000001 << d);
        e_seg = blank ? 7'h00 : exp_code[d];
        e_dp  = (!blank && d == 1) ? exp_point : 1'b0;
        e_fp  = (n % 48 == 0);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_pulse", 32'(frame_pulse), 32'(e_fp));
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n = 0;
        set_exp(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
        chk("rst_an", 32'(an), 32'h3F);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_ind", 32'(ind), 32'h0);
        chk("rst_col", 32'(col_out), 32'h0);
        chk("rst_fp", 32'(frame_pulse), 32'h0);
    endtask

    task automatic load_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5,
                             input logic p, input logic c, input logic [3:0] flags);
        lower0001 = d0; lower0010 = d1; lower0100 = d2; lower1000 = d3;
        upper01 = d4; upper10 = d5; point = p; col = c;
        {TIM, MAX, DAY, AVS} = flags;
        load = 1'b1;
        step();
        load = 1'b0;
        {lower0001, lower0010, lower0100, lower1000, upper01, upper10} = '0;
        point = 1'b0; col = 1'b0;
        {TIM, MAX, DAY, AVS} = 4'b0000;
    endtask

    initial begin
        @(posedge clock);
        do_reset();

        // Free-running scan with blank data
        run_to(96);

        // Mid-frame load shows only after the next boundary
        run_to(100);
        load_data(8'h30, 8'h30, 8'h30, 8'h33, 8'h32, 8'h31, 1'b1, 1'b0, 4'b0010);
        run_to(143);
        chk("ind_before", 32'(ind), 32'h0);
        run_to(144);
        chk("ind_day", 32'(ind), 32'h2);
        set_exp(7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h5B, 7'h06, 1'b1);
        run_to(192);

        // Two loads in one frame: last one wins
        run_to(200);
        load_data(8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 1'b0, 1'b0, 4'b0000);
        run_to(210);
        load_data(8'h32, 8'h32, 8'h32, 8'h32, 8'h32, 8'h32, 1'b0, 1'b0, 4'b0000);
        run_to(240);
        chk("ind_clear", 32'(ind), 32'h0);
        set_exp(7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 1'b0);

        // Load exactly in the boundary cycle bypasses into active
        run_to(287);
        load_data(8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 1'b0, 1'b1, 4'b1000);
        chk("ind_tim", 32'(ind), 32'h8);
        chk("col_out", 32'(col_out), 32'h1);
        set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        run_to(336);

        // Space, unknown, dash, NUL, 'E', 'r'
        run_to(340);
        load_data(8'h20, 8'h41, 8'h2D, 8'h00, 8'h45, 8'h72, 1'b0, 1'b0, 4'b0000);
        run_to(384);
        chk("col_off", 32'(col_out), 32'h0);
        set_exp(7'h00, 7'h00, 7'h40, 7'h00, 7'h79, 7'h50, 1'b0);
        run_to(432);

        // Remaining digits 4..9
        run_to(440);
        load_data(8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 1'b0, 1'b0, 4'b0000);
        run_to(480);
        set_exp(7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 1'b0);
        run_to(528);

        // Reset during digit-3 slot with data pending: pending must never appear
        run_to(530);
        load_data(8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 8'h38, 1'b1, 1'b1, 4'b1111);
        run_to(555);
        do_reset();
        run_to(96);
        chk("ind_after_rst", 32'(ind), 32'h0);
        chk("col_after_rst", 32'(col_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
